// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
// Module   : mdu_unit
// Purpose  : E-stage multiply/divide unit with architectural HI/LO registers
//            and a fixed-latency busy counter. The result is computed in the
//            accept cycle and parked in hi_tmp/lo_tmp. It is committed to
//            HI/LO when the counter expires, so the pipeline sees a
//            MIPS-style multi-cycle latency.
// Ports    : clk   - rising-edge clock
//            reset - asynchronous active-high reset (clears HI/LO/busy/count)
//            op    - MDU opcode: 0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                    5 mthi, 6 mtlo, 7 madd, 8 maddu (others = none)
//            A, B  - forwarded rs / rt operands
//            start - combinational; an arithmetic op is accepted this cycle
//            busy  - registered; a computation is in flight
//            HI/LO - registered HI and LO
// Config   : define MDU_MADD_EN to enable madd/maddu (ops 7/8)
// Revision : 1.0 - initial release
// ============================================================================
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
`endif

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] hi_tmp;
  logic [31:0] lo_tmp;
  logic        div_zero;   // pending divide had B==0: HI/LO must not change

  logic        is_arith;
  logic        is_div;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [63:0] res;

  always_comb begin
    is_div   = (op == OP_DIV) || (op == OP_DIVU);
    is_arith = (op == OP_MULT) || (op == OP_MULTU) || is_div;
`ifdef MDU_MADD_EN
    is_arith = is_arith || (op == OP_MADD) || (op == OP_MADDU);
`endif
  end

  assign start = is_arith & ~busy;

  // Products: explicit sign/zero extension to 64 bits keeps the multiply
  // width-exact for both flavours.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // One unsigned divider serves both div and divu. Signed division works on
  // magnitudes; this also makes 0x80000000 / -1 come out as 0x80000000 rem 0
  // without ever performing an overflowing signed divide.
  always_comb begin
    a_neg  = (op == OP_DIV) & A[31];
    b_neg  = (op == OP_DIV) & B[31];
    a_mag  = a_neg ? (32'd0 - A) : A;
    b_mag  = b_neg ? (32'd0 - B) : B;
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;   // result is discarded anyway
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quo    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem    = a_neg ? (32'd0 - r_mag) : r_mag;  // remainder follows dividend
  end

  always_comb begin
    res = 64'd0;
    case (op)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV,
      OP_DIVU:  res = {rem, quo};
`ifdef MDU_MADD_EN
      // Accumulate uses HI/LO as they stand at acceptance.
      OP_MADD:  res = {HI, LO} + prod_s;
      OP_MADDU: res = {HI, LO} + prod_u;
`endif
      default:  res = 64'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      cnt      <= 4'd0;
      HI       <= 32'd0;
      LO       <= 32'd0;
      hi_tmp   <= 32'd0;
      lo_tmp   <= 32'd0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            hi_tmp   <= res[63:32];
            lo_tmp   <= res[31:0];
            div_zero <= is_div && (B == 32'd0);
            cnt      <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            busy     <= 1'b1;
            state    <= RUN;
          end else if (op == OP_MTHI) begin
            HI <= A;
          end else if (op == OP_MTLO) begin
            LO <= A;
          end
        end
        RUN: begin
          // Any op seen here is dropped: the stall logic keeps them out.
          if (cnt == 4'd1) begin
            if (!div_zero) begin
              HI <= hi_tmp;
              LO <= lo_tmp;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_unit
// Purpose  : Self-checking bench for mdu_unit. Stimulus pushes the expected
//            HI/LO and busy length of every arithmetic op into a scoreboard.
//            A monitor pops and compares each time busy falls. Direct checks
//            cover reset, start, mthi/mtlo and asynchronous reset abort.
// Config   : honours MDU_MADD_EN in the same way as the design
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_unit;

  logic        clk;
  logic        reset;
  logic [3:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .op    (op),
    .A     (A),
    .B     (B),
    .start (start),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: counts busy cycles and compares HI/LO when busy falls.
  int   busy_len  = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      busy_len  = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy) begin
        busy_len++;
      end else if (prev_busy) begin
        if (sb.size() == 0) begin
          check("unexpected_completion", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("busy_len", 32'(busy_len), 32'(e.cycles));
          check("HI",       HI,            e.hi);
          check("LO",       LO,            e.lo);
        end
        busy_len = 0;
      end
      prev_busy = busy;
    end
  end

  // Caller sits just after a rising edge; op is presented for exactly one
  // cycle and start is checked while it is driven.
  task automatic issue(input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic exp_start);
    op = o; A = a; B = b;
    #1;
    check("start", {31'd0, start}, {31'd0, exp_start});
    @(posedge clk); #1;
    op = 4'd0;
    #1;
    check("start_clear", {31'd0, start}, 32'd0);
  endtask

  task automatic push(input logic [31:0] h, input logic [31:0] l, input int c);
    exp_t e;
    e.hi = h; e.lo = l; e.cycles = c;
    sb.push_back(e);
  endtask

  // Bounded wait until busy is low; leaves caller just after a rising edge.
  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; op = 4'd0; A = 32'd0; B = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  {31'd0, busy},  32'd0);
    check("rst_HI",    HI,             32'd0);
    check("rst_LO",    LO,             32'd0);
    check("rst_start", {31'd0, start}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // mult -2 * 3
    push(32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    issue(4'd1, 32'hFFFFFFFE, 32'd3, 1'b1);
    wait_idle();
    // multu same operands
    push(32'h00000002, 32'hFFFFFFFA, 5);
    issue(4'd2, 32'hFFFFFFFE, 32'd3, 1'b1);
    wait_idle();
    // div -7 / 2
    push(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    issue(4'd3, 32'hFFFFFFF9, 32'd2, 1'b1);
    wait_idle();
    // divu 7 / 0 : HI/LO untouched
    push(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    issue(4'd4, 32'd7, 32'd0, 1'b1);
    wait_idle();
    // signed overflow divide
    push(32'h00000000, 32'h80000000, 10);
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_idle();

    // mthi then mtlo on consecutive cycles
    op = 4'd5; A = 32'h12345678;
    #1 check("mthi_start", {31'd0, start}, 32'd0);
    @(posedge clk); #1;
    op = 4'd6; A = 32'h9ABCDEF0;
    #1;
    check("mthi_HI",   HI,            32'h12345678);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mtlo_start", {31'd0, start}, 32'd0);
    @(posedge clk); #1;
    op = 4'd0;
    check("mtlo_LO",   LO,            32'h9ABCDEF0);
    check("mtlo_HI",   HI,            32'h12345678);
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    // mult aborted by reset in its 3rd busy cycle (no scoreboard entry)
    issue(4'd1, 32'h10, 32'h10, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_HI",   HI,            32'd0);
    check("abort_LO",   LO,            32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // next mult runs normally: 7 * 6
    push(32'd0, 32'd42, 5);
    issue(4'd1, 32'd7, 32'd6, 1'b1);
    wait_idle();

    // back-to-back: 3*5, then -1*-1 presented in the cycle busy falls
    push(32'd0, 32'd15, 5);
    issue(4'd1, 32'd3, 32'd5, 1'b1);
    wait_idle();
    check("b2b_mfhi_LO", LO, 32'd15);
    push(32'd0, 32'd1, 5);
    issue(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    check("b2b_hold_LO", LO, 32'd15);
    wait_idle();

    // madd with HI=0, LO=0xFFFFFFFF, A=B=1
    op = 4'd5; A = 32'd0;
    @(posedge clk); #1;
    op = 4'd6; A = 32'hFFFFFFFF;
    @(posedge clk); #1;
    op = 4'd0;
`ifdef MDU_MADD_EN
    push(32'd1, 32'd0, 5);
    issue(4'd7, 32'd1, 32'd1, 1'b1);
    wait_idle();
`else
    issue(4'd7, 32'd1, 32'd1, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check("madd_off_busy", {31'd0, busy}, 32'd0);
    check("madd_off_HI",   HI,            32'd0);
    check("madd_off_LO",   LO,            32'hFFFFFFFF);
`endif

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
